// File: rtl/queue_ctrl_5x65.sv
// Ready/valid FIFO controller for a DEPTH x WIDTH two-port RAM macro (R0 read, W0 write).
// Latency: an entry written at edge N is visible at deq in cycle N+1; with FLOW=1 and the queue empty, enq passes straight to deq in the same cycle.
// Backpressure: enq_ready = ~full and does not look at deq_ready; deq_valid is held until deq_ready.
// Ports: clock/reset (async, active-high); io_enq_* producer side; io_deq_* consumer side;
//        io_count occupancy; ram_W0_* / ram_R0_* drive the external macro (R0 data is combinational).
module queue_ctrl_5x65 #(
    parameter int DEPTH  = 5,
    parameter int WIDTH  = 65,
    parameter int ADDR_W = 3,
    parameter bit FLOW   = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_enq_valid,
    output logic              io_enq_ready,
    input  logic [WIDTH-1:0]  io_enq_bits,
    output logic              io_deq_valid,
    input  logic              io_deq_ready,
    output logic [WIDTH-1:0]  io_deq_bits,
    output logic [ADDR_W-1:0] io_count,
    output logic [ADDR_W-1:0] ram_W0_addr,
    output logic              ram_W0_en,
    output logic [WIDTH-1:0]  ram_W0_data,
    output logic [ADDR_W-1:0] ram_R0_addr,
    output logic              ram_R0_en,
    input  logic [WIDTH-1:0]  ram_R0_data
);

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] enq_ptr;
    logic [ADDR_W-1:0] deq_ptr;
    logic              maybe_full;

    logic              match;
    logic              empty;
    logic              full;
    logic              live;
    logic              bypass;
    logic              do_enq;
    logic              do_deq;
    logic [ADDR_W:0]   count_wide;

    // While reset is held nothing may be written or presented, even though
    // the producer may still be driving valid.
    assign live   = ~reset;

    assign match  = (enq_ptr == deq_ptr);
    assign empty  = match & ~maybe_full;
    assign full   = match & maybe_full;

    assign bypass = FLOW & empty & io_enq_valid & live;

    assign io_enq_ready = ~full;
    assign io_deq_valid = live & (~empty | (FLOW & io_enq_valid));

    assign do_enq = live & io_enq_valid & io_enq_ready & ~(bypass & io_deq_ready);
    assign do_deq = io_deq_valid & io_deq_ready & ~bypass;

    assign ram_W0_addr = enq_ptr;
    assign ram_W0_en   = do_enq;
    assign ram_W0_data = io_enq_bits;
    assign ram_R0_addr = deq_ptr;
    assign ram_R0_en   = ~empty;

    // Forcing zero when empty keeps uninitialised RAM contents off the port.
    always_comb begin
        io_deq_bits = '0;
        if (bypass) begin
            io_deq_bits = io_enq_bits;
        end else if (!empty) begin
            io_deq_bits = ram_R0_data;
        end
    end

    // Pointers wrap at DEPTH rather than 2**ADDR_W, so the wrapped case adds DEPTH back.
    always_comb begin
        count_wide = '0;
        if (match) begin
            count_wide = maybe_full ? DEPTH_W : '0;
        end else if (enq_ptr > deq_ptr) begin
            count_wide = {1'b0, enq_ptr} - {1'b0, deq_ptr};
        end else begin
            count_wide = DEPTH_W + {1'b0, enq_ptr} - {1'b0, deq_ptr};
        end
    end

    assign io_count = ADDR_W'(count_wide);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (do_enq) begin
                enq_ptr <= (enq_ptr == LAST) ? '0 : enq_ptr + 1'b1;
            end
            if (do_deq) begin
                deq_ptr <= (deq_ptr == LAST) ? '0 : deq_ptr + 1'b1;
            end
            if (do_enq != do_deq) begin
                maybe_full <= do_enq;
            end
        end
    end

endmodule

// File: tb/tb_queue_ctrl_5x65.sv
module tb_queue_ctrl_5x65;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    // FLOW=0 instance
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [64:0] enq_bits = '0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [64:0] deq_bits;
    logic [2:0]  count;
    logic [2:0]  w0_addr;
    logic        w0_en;
    logic [64:0] w0_data;
    logic [2:0]  r0_addr;
    logic        r0_en;
    logic [64:0] r0_data;

    // FLOW=1 instance
    logic        f_enq_valid = 1'b0;
    logic        f_enq_ready;
    logic [64:0] f_enq_bits = '0;
    logic        f_deq_valid;
    logic        f_deq_ready = 1'b0;
    logic [64:0] f_deq_bits;
    logic [2:0]  f_count;
    logic [2:0]  f_w0_addr;
    logic        f_w0_en;
    logic [64:0] f_w0_data;
    logic [2:0]  f_r0_addr;
    logic        f_r0_en;
    logic [64:0] f_r0_data;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    queue_ctrl_5x65 u_dut (
        .clock(clock), .reset(reset),
        .io_enq_valid(enq_valid), .io_enq_ready(enq_ready), .io_enq_bits(enq_bits),
        .io_deq_valid(deq_valid), .io_deq_ready(deq_ready), .io_deq_bits(deq_bits),
        .io_count(count),
        .ram_W0_addr(w0_addr), .ram_W0_en(w0_en), .ram_W0_data(w0_data),
        .ram_R0_addr(r0_addr), .ram_R0_en(r0_en), .ram_R0_data(r0_data)
    );

    queue_ctrl_5x65 #(.FLOW(1'b1)) u_flow (
        .clock(clock), .reset(reset),
        .io_enq_valid(f_enq_valid), .io_enq_ready(f_enq_ready), .io_enq_bits(f_enq_bits),
        .io_deq_valid(f_deq_valid), .io_deq_ready(f_deq_ready), .io_deq_bits(f_deq_bits),
        .io_count(f_count),
        .ram_W0_addr(f_w0_addr), .ram_W0_en(f_w0_en), .ram_W0_data(f_w0_data),
        .ram_R0_addr(f_r0_addr), .ram_R0_en(f_r0_en), .ram_R0_data(f_r0_data)
    );

    // Behavioural RAM macros: synchronous write, combinational read.
    logic [64:0] mem   [5];
    logic [64:0] f_mem [5];

    always @(posedge clock) begin
        if (w0_en && w0_addr < 3'd5) mem[w0_addr] <= w0_data;
        if (f_w0_en && f_w0_addr < 3'd5) f_mem[f_w0_addr] <= f_w0_data;
    end

    assign r0_data   = (r0_addr < 3'd5) ? mem[r0_addr] : '0;
    assign f_r0_data = (f_r0_addr < 3'd5) ? f_mem[f_r0_addr] : '0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [64:0] dv(input int k);
        logic [64:0] v;
        v = {1'b1, 64'(k)};
        return v;
    endfunction

    typedef struct {
        logic        ev;
        logic [64:0] eb;
        logic        dr;
        logic        x_er;
        logic        x_dv;
        logic [64:0] x_db;
        logic [2:0]  x_cnt;
        logic        x_wen;
        logic [2:0]  x_wa;
        logic        x_ren;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic ev, input logic [64:0] eb, input logic dr,
                                input logic er, input logic dvl, input logic [64:0] db,
                                input int cnt, input logic wen, input int wa);
        vec_t v;
        v.ev = ev; v.eb = eb; v.dr = dr;
        v.x_er = er; v.x_dv = dvl; v.x_db = db;
        v.x_cnt = 3'(cnt); v.x_wen = wen; v.x_wa = 3'(wa);
        v.x_ren = (cnt != 0);
        return v;
    endfunction

    initial begin
        // Fill: five enqueues with no consumer (count 0..4 before each edge).
        vt.push_back(mk(1, dv(1), 0, 1, 0, 65'd0, 0, 1, 0));
        vt.push_back(mk(1, dv(2), 0, 1, 1, dv(1), 1, 1, 1));
        vt.push_back(mk(1, dv(3), 0, 1, 1, dv(1), 2, 1, 2));
        vt.push_back(mk(1, dv(4), 0, 1, 1, dv(1), 3, 1, 3));
        vt.push_back(mk(1, dv(5), 0, 1, 1, dv(1), 4, 1, 4));
        // Full with producer and consumer active: only the dequeue happens.
        vt.push_back(mk(1, dv(6), 1, 0, 1, dv(1), 5, 0, 0));
        // Steady enq+deq at count 4; enq pointer wraps 4->0 three times.
        for (int n = 6; n <= 22; n++)
            vt.push_back(mk(1, dv(n), 1, 1, 1, dv(n - 4), 4, 1, (n - 6) % 5));
        // One dequeue only, leaving three entries (19 out, 20..22 remain).
        vt.push_back(mk(0, 65'd0, 1, 1, 1, dv(19), 4, 0, 2));
    end

    initial begin
        // Reset held with the producer active: nothing may be written or shown.
        enq_valid = 1'b1; enq_bits = dv(9); deq_ready = 1'b1;
        f_enq_valid = 1'b1; f_enq_bits = 65'h1F; f_deq_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_enq_ready", enq_ready, 1);
        chk("rst_deq_valid", deq_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_deq_bits", deq_bits, 0);
        chk("rst_w0_en", w0_en, 0);
        chk("rst_r0_en", r0_en, 0);
        chk("rst_flow_deq_valid", f_deq_valid, 0);
        chk("rst_flow_w0_en", f_w0_en, 0);

        @(negedge clock);
        reset = 1'b0;
        enq_valid = 1'b0; enq_bits = '0; deq_ready = 1'b0;
        f_enq_valid = 1'b0; f_enq_bits = '0; f_deq_ready = 1'b0;
        #1;
        chk("idle_enq_ready", enq_ready, 1);
        chk("idle_deq_valid", deq_valid, 0);
        chk("idle_count", count, 0);
        chk("idle_deq_bits", deq_bits, 0);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clock);
            enq_valid = vt[i].ev; enq_bits = vt[i].eb; deq_ready = vt[i].dr;
            #1;
            chk($sformatf("v%0d_enq_ready", i), enq_ready, vt[i].x_er);
            chk($sformatf("v%0d_deq_valid", i), deq_valid, vt[i].x_dv);
            chk($sformatf("v%0d_deq_bits", i), deq_bits, vt[i].x_db);
            chk($sformatf("v%0d_count", i), count, vt[i].x_cnt);
            chk($sformatf("v%0d_w0_en", i), w0_en, vt[i].x_wen);
            chk($sformatf("v%0d_w0_addr", i), w0_addr, vt[i].x_wa);
            chk($sformatf("v%0d_r0_en", i), r0_en, vt[i].x_ren);
        end

        // Mid-stream reset with three entries: outputs clear without a clock edge.
        @(negedge clock);
        enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        chk("pre_rst_count", count, 3);
        chk("pre_rst_deq_bits", deq_bits, dv(20));
        #1;
        reset = 1'b1; enq_valid = 1'b1; enq_bits = 65'h55;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_deq_valid", deq_valid, 0);
        chk("async_rst_deq_bits", deq_bits, 0);
        chk("async_rst_enq_ready", enq_ready, 1);
        chk("async_rst_w0_en", w0_en, 0);

        @(negedge clock);
        reset = 1'b0; enq_valid = 1'b1; enq_bits = 65'hAA; deq_ready = 1'b0;
        #1;
        chk("post_rst_w0_en", w0_en, 1);
        chk("post_rst_w0_addr", w0_addr, 0);
        chk("post_rst_deq_valid", deq_valid, 0);
        @(negedge clock);
        enq_valid = 1'b0; enq_bits = '0; deq_ready = 1'b1;
        #1;
        chk("post_rst_first_valid", deq_valid, 1);
        chk("post_rst_first_bits", deq_bits, 65'hAA);
        chk("post_rst_count", count, 1);
        @(negedge clock);
        deq_ready = 1'b0;
        #1;
        chk("post_rst_drained", count, 0);

        // FLOW=1, empty: same-cycle pass-through, no RAM write.
        @(negedge clock);
        f_enq_valid = 1'b1; f_enq_bits = 65'h1F; f_deq_ready = 1'b1;
        #1;
        chk("flow_deq_valid", f_deq_valid, 1);
        chk("flow_deq_bits", f_deq_bits, 65'h1F);
        chk("flow_w0_en", f_w0_en, 0);
        chk("flow_count", f_count, 0);
        @(negedge clock);
        f_enq_valid = 1'b0; f_enq_bits = '0;
        #1;
        chk("flow_after_count", f_count, 0);
        chk("flow_after_deq_valid", f_deq_valid, 0);

        // FLOW=1, empty, consumer stalled: entry is stored instead.
        @(negedge clock);
        f_enq_valid = 1'b1; f_enq_bits = 65'h33; f_deq_ready = 1'b0;
        #1;
        chk("flow_stall_w0_en", f_w0_en, 1);
        chk("flow_stall_deq_bits", f_deq_bits, 65'h33);
        @(negedge clock);
        f_enq_valid = 1'b0; f_enq_bits = '0;
        #1;
        chk("flow_stored_count", f_count, 1);
        chk("flow_stored_bits", f_deq_bits, 65'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
